// File: rtl/dds_pkg.sv
// Shared definitions for the DDS modulator: mode encodings, dither LFSR
// constants and the constant function that builds the quarter-wave table.
package dds_pkg;

  typedef enum logic [1:0] {
    MODE_TONE = 2'b00,
    MODE_FSK  = 2'b01,
    MODE_BPSK = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  // Dither LFSR: 16-bit Galois form of x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // pi in Q30 fixed point.
  localparam longint PI_Q30 = 64'sd3373259426;

  // round((2^(mag_w-1)-1) * sin(pi/2 * k / 2^addr_w)), evaluated at
  // elaboration with an integer Taylor series so no real arithmetic is
  // needed in the hardware description.
  function automatic int sine_entry(input int k, input int addr_w, input int mag_w);
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint amp;
    x    = (PI_Q30 * longint'(k)) / (longint'(2) << addr_w);
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int n = 1; n <= 6; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    amp = (longint'(1) << (mag_w - 1)) - 1;
    return int'((amp * sum + (longint'(1) << 29)) >>> 30);
  endfunction

endpackage

// File: rtl/dds_modulator_if.sv
// Control and sample bus of the DDS modulator. The master drives tuning,
// strobes and symbols; the slave (the modulator) returns samples.
interface dds_modulator_if #(
  parameter int ACC_WIDTH = 16,
  parameter int MAG_WIDTH = 8
) ();

  logic                        en;
  logic                        load;
  logic [ACC_WIDTH-1:0]        ftw0;
  logic [ACC_WIDTH-1:0]        ftw1;
  logic [ACC_WIDTH-1:0]        poff;
  logic [1:0]                  mode;
  logic                        sym_stb;
  logic                        sym_bit;
  logic signed [MAG_WIDTH-1:0] sample;
  logic                        valid;

  modport master (
    output en, load, ftw0, ftw1, poff, mode, sym_stb, sym_bit,
    input  sample, valid
  );

  modport slave (
    input  en, load, ftw0, ftw1, poff, mode, sym_stb, sym_bit,
    output sample, valid
  );

endinterface

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine table with peak substitution and sign restoration.
// The registered output is the last pipeline stage of the modulator.
module sine_quarter_rom
  import dds_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int MAG_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rd_en_i,
  input  logic [ADDR_WIDTH-1:0]       addr_i,
  input  logic                        peak_i,
  input  logic                        sign_i,
  output logic signed [MAG_WIDTH-1:0] sample_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int MW1   = MAG_WIDTH - 1;
  // Full-scale magnitude 2^(MAG_WIDTH-1)-1 is all ones in MAG_WIDTH-1 bits.
  localparam logic [MAG_WIDTH-2:0] PEAK = {(MAG_WIDTH - 1){1'b1}};

  logic [MAG_WIDTH-2:0]        rom_w [DEPTH];
  logic [MAG_WIDTH-2:0]        mag_d;
  logic signed [MAG_WIDTH-1:0] sample_d;
  logic signed [MAG_WIDTH-1:0] sample_q;

  // NOTE: the table is constant logic fixed at elaboration, so it has no
  // reset and no write port; only the output register below is reset.
  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    assign rom_w[k] = MW1'(sine_entry(k, ADDR_WIDTH, MAG_WIDTH));
  end

  // Look up magnitude, substitute full scale at the quarter peak, apply sign.
  always_comb begin
    // NOTE: every output gets a value before any condition, so no latch.
    mag_d = rom_w[addr_i];
    if (peak_i) begin
      mag_d = PEAK;
    end
    sample_d = sign_i ? -$signed({1'b0, mag_d}) : $signed({1'b0, mag_d});
  end

  // Stage 3 register: updates only for a live sample, otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is written with <= so every register samples pre-edge values.
    if (rst) begin
      sample_q <= '0;
    end else if (rd_en_i) begin
      sample_q <= sample_d;
    end
  end

  assign sample_o = sample_q;

endmodule

// File: rtl/dds_modulator.sv
// DDS tone / FSK / BPSK modulator: phase accumulator, quarter-wave
// phase mapping and table lookup in a 3-stage pipeline.
// Optional build macro: DDS_PHASE_DITHER_EN adds LFSR phase dither
// below the table address before truncation.
module dds_modulator
  import dds_pkg::*;
#(
  parameter int ACC_WIDTH  = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int MAG_WIDTH  = 8
) (
  input logic            clk,
  input logic            rst,
  dds_modulator_if.slave dds
);

  localparam int PH_W   = ADDR_WIDTH + 2;
  localparam int FRAC_W = ACC_WIDTH - PH_W;
  localparam logic [ACC_WIDTH-1:0] HALF_TURN = {1'b1, {(ACC_WIDTH - 1){1'b0}}};

  // Shadow configuration and current data bit
  logic [ACC_WIDTH-1:0] ftw0_q;
  logic [ACC_WIDTH-1:0] ftw1_q;
  logic [ACC_WIDTH-1:0] poff_q;
  mode_e                mode_q;
  logic                 data_q;

  // Stage 1
  logic [ACC_WIDTH-1:0] step;
  logic [ACC_WIDTH-1:0] eff_off;
  logic [ACC_WIDTH-1:0] acc_d;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] ph1_d;
  logic [ACC_WIDTH-1:0] ph1_q;
  logic                 v1_q;

  // Stage 2
  logic [ACC_WIDTH-1:0]  ph_trunc;
  logic                  sign_d;
  logic                  mirror;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] rom_addr_d;
  logic                  peak_d;
  logic                  sign_q;
  logic [ADDR_WIDTH-1:0] rom_addr_q;
  logic                  peak_q;
  logic                  v2_q;

  // Stage 3
  logic                        valid_q;
  logic signed [MAG_WIDTH-1:0] sample_w;

  // Fractional phase bits fall away at truncation.
  logic unused_frac;
  assign unused_frac = ^ph_trunc[FRAC_W-1:0];

  // Latch the tuning set on load; the accumulator is left untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ftw0_q <= '0;
      ftw1_q <= '0;
      poff_q <= '0;
      mode_q <= MODE_TONE;
    end else if (dds.load) begin
      ftw0_q <= dds.ftw0;
      ftw1_q <= dds.ftw1;
      poff_q <= dds.poff;
      mode_q <= mode_e'(dds.mode);
    end
  end

  // Capture the data bit on the symbol strobe, independent of load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= 1'b0;
    end else if (dds.sym_stb) begin
      data_q <= dds.sym_bit;
    end
  end

  // Select step and offset from mode and data; reserved mode acts as tone.
  always_comb begin
    step    = (mode_q == MODE_FSK && data_q) ? ftw1_q : ftw0_q;
    eff_off = poff_q + ((mode_q == MODE_BPSK && data_q) ? HALF_TURN : '0);
    acc_d   = acc_q + step;
    ph1_d   = acc_q + eff_off;
  end

  // Stage 1: advance accumulator and register output phase on en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      ph1_q <= '0;
      v1_q  <= 1'b0;
    end else begin
      v1_q <= dds.en;
      if (dds.en) begin
        acc_q <= acc_d;
        ph1_q <= ph1_d;
      end
    end
  end

`ifdef DDS_PHASE_DITHER_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Galois LFSR step.
  always_comb begin
    lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
  end

  // Dither source advances once per launched sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else if (dds.en) begin
      lfsr_q <= lfsr_d;
    end
  end
`endif

  // Split the truncated phase into sign, mirror and table address.
  always_comb begin
`ifdef DDS_PHASE_DITHER_EN
    ph_trunc = ph1_q + ACC_WIDTH'(lfsr_q[FRAC_W-1:0]);
`else
    ph_trunc = ph1_q;
`endif
    sign_d     = ph_trunc[ACC_WIDTH-1];
    mirror     = ph_trunc[ACC_WIDTH-2];
    addr       = ph_trunc[ACC_WIDTH-3 -: ADDR_WIDTH];
    rom_addr_d = mirror ? -addr : addr;
    peak_d     = mirror && (addr == '0);
  end

  // Stage 2 register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q     <= 1'b0;
      rom_addr_q <= '0;
      peak_q     <= 1'b0;
      v2_q       <= 1'b0;
    end else begin
      sign_q     <= sign_d;
      rom_addr_q <= rom_addr_d;
      peak_q     <= peak_d;
      v2_q       <= v1_q;
    end
  end

  // Stage 3 valid flag, aligned with the table output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= v2_q;
    end
  end

  sine_quarter_rom #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MAG_WIDTH  (MAG_WIDTH)
  ) u_rom (
    .clk      (clk),
    .rst      (rst),
    .rd_en_i  (v2_q),
    .addr_i   (rom_addr_q),
    .peak_i   (peak_q),
    .sign_i   (sign_q),
    .sample_o (sample_w)
  );

  assign dds.sample = sample_w;
  assign dds.valid  = valid_q;

endmodule

// File: tb/tb_dds_modulator.sv
// Scoreboard bench for dds_modulator (16-bit accumulator, 64-entry table,
// 8-bit samples, dither off).
module tb_dds_modulator;

  localparam int ACC_W  = 16;
  localparam int ADDR_W = 6;
  localparam int MAG_W  = 8;

  typedef struct packed {
    logic signed [7:0] sample;
    int                cycle;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dds_modulator_if #(.ACC_WIDTH(ACC_W), .MAG_WIDTH(MAG_W)) dds ();

  dds_modulator #(
    .ACC_WIDTH  (ACC_W),
    .ADDR_WIDTH (ADDR_W),
    .MAG_WIDTH  (MAG_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .dds (dds)
  );

  exp_t              sb_q[$];
  logic signed [7:0] log_q[$];
  int                n_tests = 0;
  int                n_fail  = 0;
  int                cyc_cnt = 0;

  // Reference model state
  logic [15:0] m_ftw0, m_ftw1, m_poff, m_acc;
  logic [1:0]  m_mode;
  logic        m_data;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Ideal sine of the 8-bit truncated phase, rounded half away from zero.
  function automatic logic signed [7:0] exp_sine(input logic [15:0] ph);
    real v;
    int  r;
    v = 127.0 * $sin(6.283185307179586 * real'(ph[15:8]) / 256.0);
    r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    return 8'(r);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_ftw0 = '0; m_ftw1 = '0; m_poff = '0; m_acc = '0; m_mode = '0; m_data = 1'b0;
  endtask

  // One cycle of stimulus; pushes the expected sample when en is issued.
  task automatic cyc(input logic en, input logic stb, input logic bitv);
    logic [15:0] step;
    logic [15:0] off;
    dds.en      = en;
    dds.sym_stb = stb;
    dds.sym_bit = bitv;
    if (en) begin
      step = (m_mode == 2'b01 && m_data) ? m_ftw1 : m_ftw0;
      off  = m_poff + ((m_mode == 2'b10 && m_data) ? 16'h8000 : 16'h0000);
      sb_q.push_back('{exp_sine(m_acc + off), cyc_cnt + 3});
      m_acc = m_acc + step;
    end
    tick();
    if (stb) m_data = bitv;
    dds.en      = 1'b0;
    dds.sym_stb = 1'b0;
  endtask

  task automatic load_cfg(input logic [15:0] f0, input logic [15:0] f1,
                          input logic [15:0] po, input logic [1:0] md);
    dds.load = 1'b1;
    dds.ftw0 = f0; dds.ftw1 = f1; dds.poff = po; dds.mode = md;
    tick();
    dds.load = 1'b0;
    m_ftw0 = f0; m_ftw1 = f1; m_poff = po; m_mode = md;
  endtask

  task automatic run_en(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) begin
      if (sb_q.size() == 0) break;
      tick();
    end
    check("drain", sb_q.size(), 0);
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    sb_q.delete();
    log_q.delete();
    rst = 1'b0;
    model_reset();
  endtask

  // Monitor: pop and compare on every valid sample, check hold otherwise.
  logic signed [7:0] last_s = '0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      last_s = '0;
    end else if (dds.valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_valid_cycle", cyc_cnt, -1);
      end else begin
        e = sb_q.pop_front();
        check("sample", $signed(dds.sample), $signed(e.sample));
        check("valid_cycle", cyc_cnt, e.cycle);
      end
      log_q.push_back(dds.sample);
      last_s = dds.sample;
    end else begin
      check("hold", $signed(dds.sample), $signed(last_s));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, actual timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    dds.en = 1'b0; dds.load = 1'b0; dds.sym_stb = 1'b0; dds.sym_bit = 1'b0;
    dds.ftw0 = '0; dds.ftw1 = '0; dds.poff = '0; dds.mode = '0;
    model_reset();
    tick(); tick(); tick();
    check("reset_valid", dds.valid, 0);
    check("reset_sample", $signed(dds.sample), 0);
    rst = 1'b0;

    // Tone, period 64
    load_cfg(16'h0400, 16'h0000, 16'h0000, 2'b00);
    log_q.delete();
    run_en(65);
    drain();
    check("tone_count", log_q.size(), 65);
    check("tone_s0", $signed(log_q[0]), 0);
    check("tone_s16", $signed(log_q[16]), 127);
    check("tone_s32", $signed(log_q[32]), 0);
    check("tone_s48", $signed(log_q[48]), -127);
    check("tone_s64", $signed(log_q[64]), 0);

    // Gating: two en pulses four cycles apart
    log_q.delete();
    cyc(1'b1, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    drain();
    check("gate_pulses", log_q.size(), 2);

    // FSK: 64 samples bit 0, 64 bit 1, 64 bit 0
    do_reset();
    load_cfg(16'h0400, 16'h0800, 16'h0000, 2'b01);
    log_q.delete();
    run_en(63);
    cyc(1'b1, 1'b1, 1'b1);
    run_en(63);
    cyc(1'b1, 1'b1, 1'b0);
    run_en(64);
    drain();
    check("fsk_count", log_q.size(), 192);
    check("fsk_b0_s63", $signed(log_q[63]), -12);
    check("fsk_b1_s64", $signed(log_q[64]), 0);
    check("fsk_b1_s65", $signed(log_q[65]), 25);
    check("fsk_b1_s72", $signed(log_q[72]), 127);
    check("fsk_b1_s88", $signed(log_q[88]), -127);
    check("fsk_b1_s104", $signed(log_q[104]), 127);
    check("fsk_b0_s144", $signed(log_q[144]), 127);

    // BPSK: switch to bit 1 at the zero crossing after sample 31
    do_reset();
    load_cfg(16'h0400, 16'h0000, 16'h0000, 2'b10);
    log_q.delete();
    run_en(31);
    cyc(1'b1, 1'b1, 1'b1);
    run_en(32);
    drain();
    check("bpsk_s8", $signed(log_q[8]), 90);
    check("bpsk_s31", $signed(log_q[31]), 12);
    check("bpsk_s32", $signed(log_q[32]), 0);
    check("bpsk_s40", $signed(log_q[40]), 90);
    check("bpsk_s48", $signed(log_q[48]), 127);
    check("bpsk_s56", $signed(log_q[56]), 90);

    // Reset in mid-stream while valid is high
    run_en(5);
    check("pre_rst_valid", dds.valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_valid", dds.valid, 0);
    check("rst_async_sample", $signed(dds.sample), 0);
    sb_q.delete();
    log_q.delete();
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    run_en(2);
    drain();
    check("post_rst_count", log_q.size(), 2);
    check("post_rst_first", $signed(log_q[0]), 0);

    // Wrap and peak substitution
    do_reset();
    load_cfg(16'hFFFF, 16'h0000, 16'h4000, 2'b00);
    log_q.delete();
    run_en(4);
    drain();
    check("peak_first", $signed(log_q[0]), 127);
    check("wrap_s1", $signed(log_q[1]), 127);

    check("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
